// File: rtl/datapath_ctrl_pkg.sv
// rtl/datapath_ctrl_pkg.sv - shared opcodes, ALU codes and sequencer states
package datapath_ctrl_pkg;

    localparam logic [6:0] OPC_RTYPE   = 7'b0110011;
    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_XOR = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SLT = 4'b1010;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DECODE    = 2'd1,
        EXECUTE   = 2'd2,
        WRITEBACK = 2'd3
    } state_t;

    function automatic logic [4:0] field_rs1(input logic [31:0] instr);
        return instr[19:15];
    endfunction

    function automatic logic [4:0] field_rs2(input logic [31:0] instr);
        return instr[24:20];
    endfunction

    function automatic logic [4:0] field_rd(input logic [31:0] instr);
        return instr[11:7];
    endfunction

endpackage

// File: rtl/datapath_seq_ctrl_if.sv
// rtl/datapath_seq_ctrl_if.sv - instruction handshake and datapath control bundle
interface datapath_seq_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             instr_valid;
    logic             instr_ready;
    logic [31:0]      instr;
    logic             zero_flag;
    logic [4:0]       read_reg_num1;
    logic [4:0]       read_reg_num2;
    logic [4:0]       write_reg;
    logic [3:0]       alu_control;
    logic             regwrite;
    logic             busy;
    logic             zero_out;
    logic             illegal;
    logic [CNT_W-1:0] retired_count;

    modport master (
        output instr_valid, instr, zero_flag,
        input  instr_ready, read_reg_num1, read_reg_num2, write_reg, alu_control,
               regwrite, busy, zero_out, illegal, retired_count
    );

    modport slave (
        input  instr_valid, instr, zero_flag,
        output instr_ready, read_reg_num1, read_reg_num2, write_reg, alu_control,
               regwrite, busy, zero_out, illegal, retired_count
    );
endinterface

// File: rtl/rtype_alu_decode.sv
// rtl/rtype_alu_decode.sv - combinational RV32 R-type to ALU control decode
module rtype_alu_decode
    import datapath_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output logic [3:0]  alu_control,
    output logic        legal
);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode        = instr[6:0];
    assign funct3        = instr[14:12];
    assign funct7        = instr[31:25];
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    always_comb begin
        alu_control = ALU_ADD;
        legal       = 1'b0;
        if (opcode == OPC_RTYPE) begin
            if (funct7 == FUNCT7_BASE) begin
                legal = 1'b1;
                case (funct3)
                    3'b000:  alu_control = ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: legal = 1'b0;
                endcase
            end else if (funct7 == FUNCT7_ALT && funct3 == 3'b000) begin
                legal       = 1'b1;
                alu_control = ALU_SUB;
            end
        end
    end
endmodule

// File: rtl/datapath_seq_ctrl.sv
// rtl/datapath_seq_ctrl.sv - multi-cycle sequencer driving the register-file + ALU datapath
module datapath_seq_ctrl
    import datapath_ctrl_pkg::*;
#(
    parameter int EXEC_CYCLES = 1,
    parameter int CNT_W       = 16
) (
    input  logic               clock,
    input  logic               reset,
    datapath_seq_ctrl_if.slave bus
);
    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    state_t           state;
    logic [31:0]      instr_q;
    logic [3:0]       exec_cnt;
    logic [3:0]       dec_alu;
    logic             dec_legal;
    logic [4:0]       rs1_q;
    logic [4:0]       rs2_q;
    logic [4:0]       rd_q;
    logic [3:0]       alu_q;
    logic             regwrite_q;
    logic             illegal_q;
    logic             busy_q;
    logic             zero_q;
    logic [CNT_W-1:0] count_q;

    rtype_alu_decode u_decode (
        .instr       (instr_q),
        .alu_control (dec_alu),
        .legal       (dec_legal)
    );

    // Strobes default low every cycle so each one is exactly one cycle wide.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            instr_q    <= '0;
            exec_cnt   <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            alu_q      <= '0;
            regwrite_q <= 1'b0;
            illegal_q  <= 1'b0;
            busy_q     <= 1'b0;
            zero_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            regwrite_q <= 1'b0;
            illegal_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.instr_valid) begin
                        instr_q <= bus.instr;
                        busy_q  <= 1'b1;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    if (dec_legal) begin
                        rs1_q    <= field_rs1(instr_q);
                        rs2_q    <= field_rs2(instr_q);
                        rd_q     <= field_rd(instr_q);
                        alu_q    <= dec_alu;
                        exec_cnt <= EXEC_LOAD;
                        state    <= EXECUTE;
                    end else begin
                        illegal_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state     <= IDLE;
                    end
                end
                EXECUTE: begin
                    if (exec_cnt == 4'd0) begin
                        // x0 is hardwired; suppress the write but still retire.
                        regwrite_q <= (rd_q != 5'd0);
                        state      <= WRITEBACK;
                    end else begin
                        exec_cnt <= exec_cnt - 4'd1;
                    end
                end
                WRITEBACK: begin
                    zero_q  <= bus.zero_flag;
                    count_q <= count_q + CNT_W'(1);
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.instr_ready   = (state == IDLE);
    assign bus.read_reg_num1 = rs1_q;
    assign bus.read_reg_num2 = rs2_q;
    assign bus.write_reg     = rd_q;
    assign bus.alu_control   = alu_q;
    assign bus.regwrite      = regwrite_q;
    assign bus.illegal       = illegal_q;
    assign bus.busy          = busy_q;
    assign bus.zero_out      = zero_q;
    assign bus.retired_count = count_q;
endmodule

// File: tb/tb_datapath_seq_ctrl.sv
// tb/tb_datapath_seq_ctrl.sv - scoreboard bench for datapath_seq_ctrl
module tb_datapath_seq_ctrl;
    import datapath_ctrl_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    datapath_seq_ctrl_if #(.CNT_W(16)) ifa ();
    datapath_seq_ctrl_if #(.CNT_W(2))  ifb ();

    datapath_seq_ctrl #(.EXEC_CYCLES(1), .CNT_W(16)) dut_a (.clock(clock), .reset(reset), .bus(ifa));
    datapath_seq_ctrl #(.EXEC_CYCLES(3), .CNT_W(2))  dut_b (.clock(clock), .reset(reset), .bus(ifb));

    typedef struct {
        logic        ill;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu;
        logic        rw;
        int          rw_cyc;
        int          end_cyc;
        logic [15:0] count;
        logic        zero;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic sel = 1'b0;
    int   cnt_a = 0;
    int   cnt_b = 0;
    logic zero_model = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    logic        m_ready, m_busy, m_rw, m_ill, m_zero;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [3:0]  m_alu;
    logic [15:0] m_count;
    assign m_ready = sel ? ifb.instr_ready   : ifa.instr_ready;
    assign m_busy  = sel ? ifb.busy          : ifa.busy;
    assign m_rw    = sel ? ifb.regwrite      : ifa.regwrite;
    assign m_ill   = sel ? ifb.illegal       : ifa.illegal;
    assign m_zero  = sel ? ifb.zero_out      : ifa.zero_out;
    assign m_rs1   = sel ? ifb.read_reg_num1 : ifa.read_reg_num1;
    assign m_rs2   = sel ? ifb.read_reg_num2 : ifa.read_reg_num2;
    assign m_rd    = sel ? ifb.write_reg     : ifa.write_reg;
    assign m_alu   = sel ? ifb.alu_control   : ifa.alu_control;
    assign m_count = sel ? {14'd0, ifb.retired_count} : ifa.retired_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: an instruction ends when busy falls; pop and compare then.
    logic prev_busy = 1'b0;
    logic prev_ill  = 1'b0;
    int   rw_n = 0;
    int   rw_at = -1;
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            prev_busy = 1'b0;
            prev_ill  = 1'b0;
            rw_n      = 0;
        end else begin
            if (prev_ill) check("illegal_width", {31'd0, m_ill}, 32'd0);
            if (m_rw) begin
                rw_n++;
                rw_at = cyc;
            end
            if (prev_busy && !m_busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_retire", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("end_cycle", cyc, e.end_cyc);
                    check("illegal", {31'd0, m_ill}, {31'd0, e.ill});
                    check("regwrite_pulses", rw_n, e.rw ? 1 : 0);
                    if (e.rw) check("regwrite_cycle", rw_at, e.rw_cyc);
                    check("retired_count", {16'd0, m_count}, {16'd0, e.count});
                    check("zero_out", {31'd0, m_zero}, {31'd0, e.zero});
                    if (!e.ill) begin
                        check("read_reg_num1", {27'd0, m_rs1}, {27'd0, e.rs1});
                        check("read_reg_num2", {27'd0, m_rs2}, {27'd0, e.rs2});
                        check("write_reg", {27'd0, m_rd}, {27'd0, e.rd});
                        check("alu_control", {28'd0, m_alu}, {28'd0, e.alu});
                    end
                end
                rw_n = 0;
            end
            prev_busy = m_busy;
            prev_ill  = m_ill;
        end
    end

    task automatic drive(input logic v, input logic [31:0] w, input logic z);
        if (sel) begin
            ifb.instr_valid = v; ifb.instr = w; ifb.zero_flag = z;
        end else begin
            ifa.instr_valid = v; ifa.instr = w; ifa.zero_flag = z;
        end
    endtask

    task automatic issue(input logic [31:0] w, input logic legal, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic [3:0] alu,
                         input logic z, input logic hold, input logic track, output int k);
        exp_t e;
        int   ex;
        bit   got;
        got = 0;
        k   = -1;
        ex  = sel ? 3 : 1;
        for (int t = 0; t < 40; t++) begin
            if (m_ready) begin
                got = 1;
                break;
            end
            @(negedge clock);
        end
        if (!got) begin
            check("accept_timeout", 32'd0, 32'd1);
            return;
        end
        drive(1'b1, w, z);
        k = cyc + 1;
        if (track) begin
            e.ill = !legal; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.alu = alu;
            e.rw = legal && (rd != 5'd0);
            if (legal) begin
                if (sel) cnt_b++; else cnt_a++;
                zero_model = z;
                e.rw_cyc  = k + ex + 1;
                e.end_cyc = k + ex + 2;
            end else begin
                e.rw_cyc  = -1;
                e.end_cyc = k + 1;
            end
            e.count = sel ? 16'(cnt_b % 4) : 16'(cnt_a);
            e.zero  = zero_model;
            exp_q.push_back(e);
        end
        @(posedge clock);
        #1;
        if (!hold) drive(1'b0, w, z);
    endtask

    task automatic drain();
        for (int t = 0; t < 60 && exp_q.size() > 0; t++) @(negedge clock);
        if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 32'd0);
        @(negedge clock);
    endtask

    initial begin
        int k, kp;
        sel = 1'b0;
        drive(1'b0, 32'd0, 1'b0);
        sel = 1'b1;
        drive(1'b0, 32'd0, 1'b0);
        sel = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_regwrite", {31'd0, ifa.regwrite}, 32'd0);
        check("rst_busy", {31'd0, ifa.busy}, 32'd0);
        check("rst_count", {16'd0, ifa.retired_count}, 32'd0);
        check("rst_ready", {31'd0, ifa.instr_ready}, 32'd1);
        reset = 1'b1;
        @(negedge clock);

        issue(32'h002081B3, 1, 5'd1, 5'd2, 5'd3, ALU_ADD, 1'b0, 0, 1, k); drain();
        issue(32'h401082B3, 1, 5'd1, 5'd1, 5'd5, ALU_SUB, 1'b1, 0, 1, k); drain();
        issue(32'h00000013, 0, 5'd0, 5'd0, 5'd0, ALU_ADD, 1'b0, 0, 1, k);
        @(negedge clock);
        check("illegal_ready_k", {31'd0, ifa.instr_ready}, 32'd0);
        @(negedge clock);
        check("illegal_ready_k1", {31'd0, ifa.instr_ready}, 32'd1);
        drain();
        issue(32'h00208033, 1, 5'd1, 5'd2, 5'd0, ALU_ADD, 1'b0, 0, 1, k); drain();
        issue(32'h403150B3, 0, 5'd0, 5'd0, 5'd0, ALU_ADD, 1'b0, 0, 1, k); drain();
        issue(32'h003130B3, 0, 5'd0, 5'd0, 5'd0, ALU_ADD, 1'b0, 0, 1, k); drain();
        issue(32'h022081B3, 0, 5'd0, 5'd0, 5'd0, ALU_ADD, 1'b0, 0, 1, k); drain();
        issue(32'h006243B3, 1, 5'd4, 5'd6, 5'd7, ALU_XOR, 1'b0, 0, 1, k); drain();
        issue(32'h0062A233, 1, 5'd5, 5'd6, 5'd4, ALU_SLT, 1'b1, 0, 1, k); drain();

        // Reset in the middle of EXECUTE.
        issue(32'h002081B3, 1, 5'd1, 5'd2, 5'd3, ALU_ADD, 1'b0, 0, 0, k);
        @(negedge clock);
        @(negedge clock);
        check("pre_rst_busy", {31'd0, ifa.busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, ifa.busy}, 32'd0);
        check("mid_rst_zero_out", {31'd0, ifa.zero_out}, 32'd0);
        check("mid_rst_count", {16'd0, ifa.retired_count}, 32'd0);
        check("mid_rst_regs", {17'd0, ifa.read_reg_num1, ifa.read_reg_num2, ifa.write_reg},
              32'd0);
        check("mid_rst_alu", {28'd0, ifa.alu_control}, 32'd0);
        check("mid_rst_ready", {31'd0, ifa.instr_ready}, 32'd1);
        cnt_a = 0;
        zero_model = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clock);
            check("post_rst_regwrite", {31'd0, ifa.regwrite}, 32'd0);
            check("post_rst_ready", {31'd0, ifa.instr_ready}, 32'd1);
        end

        // Back-to-back stream on the EXEC_CYCLES=3, 2-bit counter instance.
        sel = 1'b1;
        issue(32'h00C5E533, 1, 5'd11, 5'd12, 5'd10, ALU_OR, 1'b0, 1, 1, kp);
        issue(32'h01DF7FB3, 1, 5'd30, 5'd29, 5'd31, ALU_AND, 1'b1, 1, 1, k);
        check("accept_period_2", k - kp, 32'd6);
        kp = k;
        issue(32'h00419133, 1, 5'd3, 5'd4, 5'd2, ALU_SLL, 1'b0, 1, 1, k);
        check("accept_period_3", k - kp, 32'd6);
        kp = k;
        issue(32'h0014D433, 1, 5'd9, 5'd1, 5'd8, ALU_SRL, 1'b1, 0, 1, k);
        check("accept_period_4", k - kp, 32'd6);
        drain();
        check("wrap_count", {30'd0, ifb.retired_count}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
